div_share_ctrl: RTL and testbench

- Shares one 24-bit multi-cycle Newton divider (start/busy interface, result on q) among NUM_REQ requesters.
- Arbitrates requests round-robin and sequences the divider's start/busy protocol, holding operands stable for the whole operation.
- Returns each result with the requester ID through a valid/ready response port.
- Sits between the FP/fixed-point requesters and the divider instance.

---
 rtl/div_share_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_div_share_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_share_ctrl.sv
// div_share_ctrl: shares one multi-cycle 24-bit divider among NUM_REQ
// requesters. Round-robin grant, start/busy sequencing with operand hold,
// WAIT/RUN watchdogs, and a valid/ready response carrying the requester id.
module div_share_ctrl #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [24*NUM_REQ-1:0]   req_a,
  input  logic [24*NUM_REQ-1:0]   req_b,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [ID_W-1:0]         resp_id,
  output logic [23:0]             resp_q,
  output logic                    resp_err,
  output logic                    div_start,
  output logic                    div_enable,
  output logic [23:0]             div_a,
  output logic [23:0]             div_b,
  input  logic                    div_busy,
  input  logic [23:0]             div_q
);

  // Counter wide enough for both the RUN watchdog and the 4-cycle WAIT limit.
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 3) ? $clog2(TIMEOUT + 1) : 3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_RUN   = 3'd3,
    S_RESP  = 3'd4
  } state_e;

  state_e           state_q;
  logic [ID_W-1:0]  ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [23:0]      op_a_q;
  logic [23:0]      op_b_q;
  logic [ID_W-1:0]  op_id_q;
  logic             div_start_q;
  logic             div_enable_q;
  logic             resp_valid_q;
  logic [23:0]      resp_q_q;
  logic             resp_err_q;

  logic             grant_vld_s;
  logic [ID_W-1:0]  grant_idx_s;
  logic [23:0]      grant_a_s;
  logic [23:0]      grant_b_s;
  int               dist_s;
  int               best_s;

  // Round-robin pick: smallest distance above the last-granted pointer wins.
  always_comb begin
    grant_vld_s = |req_valid;
    grant_idx_s = {ID_W{1'b0}};
    best_s      = NUM_REQ;
    dist_s      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      dist_s = (i + NUM_REQ - int'(ptr_q) - 1) % NUM_REQ;
      if (req_valid[i] && (dist_s < best_s)) begin
        best_s      = dist_s;
        grant_idx_s = ID_W'(i);
      end else begin
        best_s      = best_s;
      end
    end
  end

  // Operand mux for the granted requester.
  always_comb begin
    grant_a_s = 24'h000000;
    grant_b_s = 24'h000000;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx_s == ID_W'(i)) begin
        grant_a_s = req_a[i*24 +: 24];
        grant_b_s = req_b[i*24 +: 24];
      end else begin
        grant_a_s = grant_a_s;
      end
    end
  end

  // One-hot accept strobe, only while waiting for work.
  always_comb begin
    req_ready = {NUM_REQ{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = (state_q == S_IDLE) && grant_vld_s && (grant_idx_s == ID_W'(i));
    end
  end

  // Controller FSM: accept, start pulse, busy tracking with watchdogs, response hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      ptr_q        <= ID_W'(NUM_REQ - 1);
      cnt_q        <= {CNT_W{1'b0}};
      op_a_q       <= 24'h000000;
      op_b_q       <= 24'h000000;
      op_id_q      <= {ID_W{1'b0}};
      div_start_q  <= 1'b0;
      div_enable_q <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_q_q     <= 24'h000000;
      resp_err_q   <= 1'b0;
    end else begin
      div_enable_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          div_start_q <= 1'b0;
          cnt_q       <= {CNT_W{1'b0}};
          if (grant_vld_s) begin
            op_a_q  <= grant_a_s;
            op_b_q  <= grant_b_s;
            op_id_q <= grant_idx_s;
            ptr_q   <= grant_idx_s;
            if (grant_b_s[23]) begin
              state_q     <= S_ISSUE;
              div_start_q <= 1'b1;
            end else begin
              // Unnormalised divisor: answer with an error, divider untouched.
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_q_q     <= 24'h000000;
              resp_err_q   <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          div_start_q <= 1'b0;
          cnt_q       <= {CNT_W{1'b0}};
          state_q     <= S_WAIT;
        end
        S_WAIT: begin
          if (div_busy) begin
            state_q <= S_RUN;
            cnt_q   <= {CNT_W{1'b0}};
          end else if (cnt_q == CNT_W'(3)) begin
            state_q      <= S_RESP;
            resp_valid_q <= 1'b1;
            resp_q_q     <= 24'h000000;
            resp_err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_RUN: begin
          if (!div_busy) begin
            state_q      <= S_RESP;
            resp_valid_q <= 1'b1;
            resp_q_q     <= div_q;
            resp_err_q   <= 1'b0;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            state_q      <= S_RESP;
            resp_valid_q <= 1'b1;
            resp_q_q     <= 24'h000000;
            resp_err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        default: begin
          state_q      <= S_IDLE;
          div_start_q  <= 1'b0;
          resp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Operands come straight from the op registers, so they cannot move mid-divide.
  assign div_a      = op_a_q;
  assign div_b      = op_b_q;
  assign div_start  = div_start_q;
  assign div_enable = div_enable_q;
  assign resp_valid = resp_valid_q;
  assign resp_id    = op_id_q;
  assign resp_q     = resp_q_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_div_share_ctrl.sv
// Self-checking bench for div_share_ctrl: directed scenarios plus randomized
// traffic against a behavioural round-robin / latency reference model.
module tb_div_share_ctrl;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int TIMEOUT = 64;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [24*NUM_REQ-1:0] req_a;
  logic [24*NUM_REQ-1:0] req_b;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [ID_W-1:0]       resp_id;
  logic [23:0]           resp_q;
  logic                  resp_err;
  logic                  div_start;
  logic                  div_enable;
  logic [23:0]           div_a;
  logic [23:0]           div_b;
  logic                  div_busy = 1'b0;
  logic [23:0]           div_q = 24'h000000;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;
  int exp_ptr = NUM_REQ - 1;

  // Divider model controls: 0 normal, 1 never busy, 2 busy stuck high.
  int          dm_mode  = 0;
  int          dm_len   = 16;
  bit          dm_fixed = 1'b0;
  logic [23:0] dm_fix_q = 24'h000000;
  bit          dm_clear = 1'b0;
  int          dm_cnt   = 0;

  div_share_ctrl #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_q(resp_q), .resp_err(resp_err),
    .div_start(div_start), .div_enable(div_enable), .div_a(div_a), .div_b(div_b),
    .div_busy(div_busy), .div_q(div_q)
  );

  always #5 clk = ~clk;

  // Fixed-point quotient a/b in Q1.23, truncated to 24 bits.
  function automatic logic [23:0] ref_div(input logic [23:0] a, input logic [23:0] b);
    logic [47:0] n;
    n = {1'b0, a, 23'd0};
    return 24'(n / {24'd0, b});
  endfunction

  // Round-robin reference: first valid requester after ptr, with wrap.
  function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int ptr);
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx;
      idx = (ptr + k) % NUM_REQ;
      if (((v >> idx) & 4'b0001) != 4'b0000) return idx;
    end
    return -1;
  endfunction

  // Divider model: busy for dm_len cycles after start, result from held operands.
  always @(posedge clk) begin
    if (dm_clear) begin
      div_busy <= 1'b0;
      dm_cnt   <= 0;
    end else if (div_start && !div_busy && dm_mode != 1) begin
      div_busy <= 1'b1;
      dm_cnt   <= dm_len;
    end else if (div_busy && dm_mode == 0) begin
      if (dm_cnt == 1) begin
        div_busy <= 1'b0;
        div_q    <= dm_fixed ? dm_fix_q : ref_div(div_a, div_b);
      end else begin
        dm_cnt <= dm_cnt - 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [23:0] a, input logic [23:0] b);
    req_a[24*i +: 24] = a;
    req_b[24*i +: 24] = b;
  endtask

  // One full transaction: grant, latency, operand hold, response, optional stall.
  task automatic serve(input int stall, input bit scramble);
    int          exp_id, exp_lat, exp_starts, lat, starts;
    logic [23:0] ea, eb, eq, hq;
    logic        ee, he, ops_ok, rdy_seen;
    logic [ID_W-1:0] hid;
    resp_ready = 1'b0;
    #1;
    exp_id = rr_pick(req_valid, exp_ptr);
    if (exp_id < 0) begin
      chk("idle_no_grant", 32'(req_ready), 32'd0);
      return;
    end
    chk("grant", 32'(req_ready), 32'd1 << exp_id);
    ea = 24'(req_a >> (24 * exp_id));
    eb = 24'(req_b >> (24 * exp_id));
    if (!eb[23]) begin
      exp_lat = 0; eq = 24'h000000; ee = 1'b1; exp_starts = 0;
    end else if (dm_mode == 0) begin
      exp_lat = dm_len + 2; eq = dm_fixed ? dm_fix_q : ref_div(ea, eb); ee = 1'b0; exp_starts = 1;
    end else if (dm_mode == 1) begin
      exp_lat = 5; eq = 24'h000000; ee = 1'b1; exp_starts = 1;
    end else begin
      exp_lat = TIMEOUT + 2; eq = 24'h000000; ee = 1'b1; exp_starts = 1;
    end
    exp_ptr = exp_id;
    @(negedge clk);
    lat = 0; starts = 0; ops_ok = 1'b1; rdy_seen = 1'b0;
    while (!resp_valid && lat < 200) begin
      if (div_start) starts++;
      if (div_a !== ea || div_b !== eb) ops_ok = 1'b0;
      if (req_ready !== 4'b0000) rdy_seen = 1'b1;
      if (scramble) begin
        req_a = {$urandom, $urandom, $urandom};
        req_b = {$urandom, $urandom, $urandom};
      end
      @(negedge clk);
      lat++;
    end
    chk("resp_valid", 32'(resp_valid), 32'd1);
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("start_pulses", 32'(starts), 32'(exp_starts));
    chk("start_low_in_resp", 32'(div_start), 32'd0);
    chk("ops_stable", 32'(ops_ok), 32'd1);
    chk("no_ready_busy", 32'(rdy_seen), 32'd0);
    chk("resp_id", 32'(resp_id), 32'(exp_id));
    chk("resp_q", 32'(resp_q), 32'(eq));
    chk("resp_err", 32'(resp_err), 32'(ee));
    hid = resp_id; hq = resp_q; he = resp_err;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("stall_valid", 32'(resp_valid), 32'd1);
      chk("stall_id", 32'(resp_id), 32'(hid));
      chk("stall_q", 32'(resp_q), 32'(hq));
      chk("stall_err", 32'(resp_err), 32'(he));
      chk("stall_ready", 32'(req_ready), 32'd0);
      chk("stall_start", 32'(div_start), 32'd0);
    end
    chk("hs_bubble", 32'(req_ready), 32'd0);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("resp_cleared", 32'(resp_valid), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_id"}, 32'(resp_id), 32'd0);
    chk({tag, "_q"}, 32'(resp_q), 32'd0);
    chk({tag, "_err"}, 32'(resp_err), 32'd0);
    chk({tag, "_start"}, 32'(div_start), 32'd0);
    chk({tag, "_enable"}, 32'(div_enable), 32'd1);
    chk({tag, "_a"}, 32'(div_a), 32'd0);
    chk({tag, "_b"}, 32'(div_b), 32'd0);
  endtask

  initial begin
    logic seen;
    logic [23:0] rb;
    rst = 1'b0; req_valid = 4'b0000; req_a = '0; req_b = '0; resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b1;
    @(negedge clk);

    // Nothing requested: stay idle.
    for (int c = 0; c < 3; c++) begin
      chk("idle_ready", 32'(req_ready), 32'd0);
      chk("idle_start", 32'(div_start), 32'd0);
      @(negedge clk);
    end

    // Single request from requester 0 with a fixed divider answer.
    dm_fixed = 1'b1; dm_fix_q = 24'h123456; dm_len = 16;
    set_req(0, 24'hC00000, 24'h800000);
    req_valid = 4'b0001;
    serve(0, 1'b0);
    req_valid = 4'b0000;
    dm_fixed = 1'b0;

    // All requesters continuously valid: rotation 1,2,3,0,1.
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 24'($urandom), {1'b1, 23'($urandom)});
    req_valid = 4'b1111;
    for (int n = 0; n < 5; n++) serve(0, 1'b0);
    req_valid = 4'b0000;

    // Unnormalised divisor from requester 2.
    set_req(2, 24'h654321, 24'h400000);
    req_valid = 4'b0100;
    serve(0, 1'b0);

    // Response stalled for 10 cycles.
    set_req(1, 24'hABCDEF, 24'h9FFFFF);
    req_valid = 4'b0010;
    serve(10, 1'b0);

    // Divider never goes busy.
    dm_mode = 1;
    set_req(3, 24'h111111, 24'h800001);
    req_valid = 4'b1000;
    serve(0, 1'b0);

    // Divider busy stuck high: RUN watchdog.
    dm_mode = 2;
    req_valid = 4'b0001;
    serve(0, 1'b0);
    req_valid = 4'b0000;
    // Busy still high while idle must not start anything.
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid || div_start || req_ready != 4'b0000) seen = 1'b1;
    end
    chk("busy_in_idle_ignored", 32'(seen), 32'd0);
    dm_clear = 1'b1;
    @(negedge clk);
    dm_clear = 1'b0;
    dm_mode = 0;

    // Randomized traffic.
    for (int n = 0; n < 30; n++) begin
      dm_len = $urandom_range(1, 20);
      for (int i = 0; i < NUM_REQ; i++) begin
        rb = 24'($urandom);
        if ($urandom_range(0, 3) != 0) rb[23] = 1'b1;
        set_req(i, 24'($urandom), rb);
      end
      req_valid = 4'($urandom_range(1, 15));
      serve($urandom_range(0, 3), 1'b1);
    end
    req_valid = 4'b0000;

    // Reset pulsed in the middle of RUN.
    dm_len = 16;
    set_req(2, 24'h345678, 24'h9ABCDE);
    req_valid = 4'b0100;
    #1;
    chk("pre_rst_grant", 32'(req_ready), 32'h4);
    @(negedge clk);
    req_valid = 4'b0000;
    repeat (6) @(negedge clk);
    rst = 1'b0;
    #1;
    chk_reset_outputs("midrun_reset");
    dm_clear = 1'b1;
    repeat (2) @(negedge clk);
    dm_clear = 1'b0;
    rst = 1'b1;
    exp_ptr = NUM_REQ - 1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (resp_valid || div_start) seen = 1'b1;
    end
    chk("no_resp_after_reset", 32'(seen), 32'd0);
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 24'($urandom), {1'b1, 23'($urandom)});
    req_valid = 4'b1111;
    serve(0, 1'b0);
    chk("post_reset_first_id_is0", 32'(exp_ptr), 32'd0);
    req_valid = 4'b0000;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
